// File: rtl/rv32_pkg.sv
// rv32_pkg: shared constants and types for the RV32M divide unit.
// Provides funct3 codes, divider FSM states, iteration count and special-case values.
package rv32_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam int DIV_ITERS = 32;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_t;

    function automatic logic [31:0] mag(
        input logic [31:0] v,
        input logic        neg
    );
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage <-> divider bundle.
// master: start_e, funct3_e, src_a_e, src_b_e, flush_e -> ; <- busy, done, result.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            start_e;
    logic [2:0]      funct3_e;
    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] src_b_e;
    logic            flush_e;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_e, funct3_e, src_a_e, src_b_e, flush_e,
        input  busy, done, result
    );

    modport slave (
        input  start_e, funct3_e, src_a_e, src_b_e, flush_e,
        output busy, done, result
    );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one restoring radix-2 step (33-bit trial subtract, shift).
// Ports: i_rem, i_msb, i_div in; o_rem (next partial remainder), o_q (quotient bit) out.
module div_step (
    input  logic [31:0] i_rem,
    input  logic        i_msb,
    input  logic [31:0] i_div,
    output logic [31:0] o_rem,
    output logic        o_q
);
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // i_rem < i_div, so the true difference fits 33-bit two's complement.
    assign w_shift = {i_rem, i_msb};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign o_q     = ~w_diff[32];
    assign o_rem   = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU divider, 34-cycle latency.
// Ports: clk, rst_n, bus (div_unit_if.slave). Macro DIV_EARLY_OUT_EN: trivial-case skip.
module div_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    div_unit_if.slave   bus
);
    div_state_t      r_state;
    div_state_t      w_next;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_raw_a;
    logic [XLEN-1:0] r_result;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_by0;
    logic            r_ovf;

    logic            w_sgn;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_by0;
    logic            w_ovf;
    logic            w_accept;
    logic [XLEN-1:0] w_step_rem;
    logic            w_step_q;
    logic [XLEN-1:0] w_fix_q;
    logic [XLEN-1:0] w_fix_r;
    logic            w_busy;
    logic            w_done;

    assign w_sgn    = ~bus.funct3_e[0];
    assign w_a_neg  = w_sgn & bus.src_a_e[XLEN-1];
    assign w_b_neg  = w_sgn & bus.src_b_e[XLEN-1];
    assign w_abs_a  = mag(bus.src_a_e, w_a_neg);
    assign w_abs_b  = mag(bus.src_b_e, w_b_neg);
    assign w_by0    = (bus.src_b_e == '0);
    assign w_ovf    = w_sgn & (bus.src_a_e == INT_MIN)
                    & (bus.src_b_e == '1);
    assign w_accept = (r_state == S_IDLE) & bus.start_e
                    & ~bus.flush_e;

`ifdef DIV_EARLY_OUT_EN
    logic w_small;
    logic w_skip;
    logic r_small;
    assign w_small = (w_abs_a < w_abs_b);
    assign w_skip  = w_by0 | w_ovf | w_small;
`endif

    div_step u_step (
        .i_rem (r_rem),
        .i_msb (r_a[XLEN-1]),
        .i_div (r_b),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // Sign fix-up and special-case overrides, evaluated in FIX.
    always_comb begin
        w_fix_q = r_neg_q ? (XLEN'(0) - r_a) : r_a;
        w_fix_r = r_neg_r ? (XLEN'(0) - r_rem) : r_rem;
        unique case (1'b1)
            r_by0: begin
                w_fix_q = DIV_BY_ZERO_Q;
                w_fix_r = r_raw_a;
            end
            r_ovf: begin
                w_fix_q = INT_MIN;
                w_fix_r = '0;
            end
`ifdef DIV_EARLY_OUT_EN
            r_small: begin
                w_fix_q = '0;
                w_fix_r = r_raw_a;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_busy = 1'b1;
`ifdef DIV_EARLY_OUT_EN
                    w_next = w_skip ? S_FIX : S_CALC;
`else
                    w_next = S_CALC;
`endif
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == 5'd0) w_next = S_FIX;
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = ~bus.flush_e;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.flush_e) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_raw_a  <= '0;
            r_result <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_by0    <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            r_small  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_cnt    <= 5'(DIV_ITERS - 1);
                r_a      <= w_abs_a;
                r_b      <= w_abs_b;
                r_rem    <= '0;
                r_raw_a  <= bus.src_a_e;
                r_is_rem <= bus.funct3_e[1];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_by0    <= w_by0;
                r_ovf    <= w_ovf;
`ifdef DIV_EARLY_OUT_EN
                r_small  <= w_small;
`endif
            end else if (r_state == S_CALC && !bus.flush_e) begin
                // Dividend shifts out the top while quotient bits fill the bottom.
                r_rem <= w_step_rem;
                r_a   <= {r_a[XLEN-2:0], w_step_q};
                r_cnt <= r_cnt - 5'd1;
            end
            if (r_state == S_FIX && !bus.flush_e)
                r_result <= r_is_rem ? w_fix_r : w_fix_q;
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit.
// Table vectors, flush/reset sequences and random ops against a reference model.
module tb_div_unit;
    import rv32_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h", nm, got, exp);
    endtask

    function automatic logic is_signed(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Arithmetic reference: truncating division, RISC-V special cases.
    function automatic logic [31:0] ref_div(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (is_signed(f3)) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return (f3 == F3_REM || f3 == F3_REMU) ? r : q;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        longint ma;
        longint mb;
        if (is_signed(f3)) begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = longint'({32'd0, a});
            mb = longint'({32'd0, b});
        end
        if (b == 32'd0 || ma < mb) return 2;
        if (is_signed(f3) && a == INT_MIN && b == 32'hFFFF_FFFF)
            return 2;
`else
        if (f3 == 3'b000 && a == b + 32'd1) return 34;
`endif
        return 34;
    endfunction

    task automatic run_op(input string nm, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv);
        int lat;
        int dcyc;
        logic busy_ok;
        logic [31:0] got;
        lat = exp_lat(f3, a, b);
        dcyc = -1;
        busy_ok = 1'b1;
        got = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.start_e  = 1'b1;
        bus.funct3_e = f3;
        bus.src_a_e  = a;
        bus.src_b_e  = b;
        for (int c = 0; c < 40 && dcyc < 0; c++) begin
            @(negedge clk);
            if (bus.busy !== (c < lat)) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                dcyc = c;
                got = bus.result;
            end
            if (dcyc < 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        bus.start_e = 1'b0;
        chk({nm, "_busy"}, 32'(busy_ok), 32'd1);
        chk({nm, "_lat"}, 32'(dcyc), 32'(lat));
        chk({nm, "_res"}, got, expv);
        @(negedge clk);
        chk({nm, "_hold"}, bus.result, expv);
    endtask

    initial begin
        logic [31:0] last_exp;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        seen;
        logic        moved;

        tv[0]  = '{F3_DIVU, 32'd100, 32'd7, 32'd14};
        tv[1]  = '{F3_REMU, 32'd100, 32'd7, 32'd2};
        tv[2]  = '{F3_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD};
        tv[3]  = '{F3_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF};
        tv[4]  = '{F3_DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD};
        tv[5]  = '{F3_REM, 32'd7, -32'sd2, 32'd1};
        tv[6]  = '{F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF};
        tv[7]  = '{F3_REMU, 32'd5, 32'd0, 32'd5};
        tv[8]  = '{F3_DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        tv[9]  = '{F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tv[10] = '{F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        tv[11] = '{F3_DIVU, 32'd3, 32'd10, 32'd0};
        tv[12] = '{F3_REMU, 32'd3, 32'd10, 32'd3};
        tv[13] = '{F3_REM, -32'sd5, 32'd0, 32'hFFFF_FFFB};
        tv[14] = '{F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};

        bus.start_e  = 1'b0;
        bus.flush_e  = 1'b0;
        bus.funct3_e = 3'b000;
        bus.src_a_e  = '0;
        bus.src_b_e  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        rst_n = 1'b1;

        foreach (tv[i])
            run_op($sformatf("tv%0d", i), tv[i].f3, tv[i].a,
                   tv[i].b, tv[i].exp);
        last_exp = tv[14].exp;

        // Flush in cycle 10 of a DIVU.
        @(posedge clk); #1;
        bus.start_e  = 1'b1;
        bus.funct3_e = F3_DIVU;
        bus.src_a_e  = 32'd1000;
        bus.src_b_e  = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.flush_e = 1'b1;
        @(negedge clk);
        chk("flush_busy_c10", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.flush_e = 1'b0;
        bus.start_e = 1'b0;
        @(negedge clk);
        chk("flush_busy_c11", 32'(bus.busy), 32'd0);
        seen = 1'b0;
        moved = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen = 1'b1;
            if (bus.result !== last_exp) moved = 1'b1;
        end
        chk("flush_no_done", 32'(seen), 32'd0);
        chk("flush_res_kept", 32'(moved), 32'd0);
        run_op("after_flush", F3_DIVU, 32'd9, 32'd3, 32'd3);

        // Async reset in cycle 20.
        @(posedge clk); #1;
        bus.start_e  = 1'b1;
        bus.funct3_e = F3_DIVU;
        bus.src_a_e  = 32'd100;
        bus.src_b_e  = 32'd7;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.start_e = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_result", bus.result, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        chk("arst_no_done", 32'(seen), 32'd0);
        run_op("after_rst", F3_DIVU, 32'd100, 32'd7, 32'd14);

        for (int i = 0; i < 40; i++) begin
            rf3 = F3_DIV + 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(0, 15));
                2: rb = 32'd0 - 32'($urandom_range(1, 4));
                3: rb = ra >> $urandom_range(0, 31);
                default: begin
                    ra = INT_MIN;
                    rb = 32'hFFFF_FFFF;
                end
            endcase
            run_op($sformatf("rnd%0d", i), rf3, ra, rb,
                   ref_div(rf3, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the execute stage beside the ALU. It takes forwarded operands from the execute-stage muxes and drives `busy` to the hazard unit, which ORs it into stall_f/stall_d and a hold of the execute register. It returns a 32-bit result with a one-cycle `done` pulse when the instruction may advance to memory. MUL* instructions are handled elsewhere.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_e`  in  1  a divide instruction is present in execute
- `funct3_e`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- `src_a_e`  in  32  dividend (post-forwarding)
- `src_b_e`  in  32  divisor (post-forwarding)
- `flush_e`  in  1  execute-stage flush from hazard unit; aborts operation
- `busy`  out  1  stall request to hazard unit
- `done`  out  1  result valid this cycle; one-cycle pulse
- `result`  out  32  quotient or remainder per funct3; held until next accepted start

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset: state IDLE, `result`=0, `done`=0, counter=0; `busy`=0 while `start_e`=0.
- IDLE: `start_e`=1 and `flush_e`=0 latch operands, funct3, and sign flags, then go to CALC with counter=31.
- Signed ops use magnitudes |a| and |b|. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign. Unsigned ops use raw values.
- CALC, restoring step: rem = {rem[31:0], a[31]} − b over 33 bits. If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0. After counter=0, go to FIX.
- FIX: apply sign correction, then select quotient (DIV/DIVU) or remainder (REM/REMU) into `result`. Go to DONE.
- Special cases in FIX override the datapath:
  - Divisor 0: quotient=0xFFFFFFFF and remainder=dividend, for both signed and unsigned.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0.
- DONE: `done`=1, `busy`=0. Return to IDLE next cycle. `start_e` is ignored in DONE because the same instruction is still in execute.
- `flush_e`=1 in any state: next state IDLE, no `done` pulse, `result` unchanged. `flush_e` takes priority over `start_e`.
- `busy` = (IDLE & `start_e` & !`flush_e`) | CALC | FIX. It is combinational so that the stall is applied in the accepting cycle.
- Reset asserted mid-operation returns to IDLE immediately; there is no `done` pulse.

## Timing
- Cycle 0: start accepted in IDLE, `busy`=1.
- Cycles 1–32: CALC, `busy`=1.
- Cycle 33: FIX, `busy`=1.
- Cycle 34: DONE, `done`=1, `busy`=0, `result` valid. The instruction advances to memory at the end of cycle 34.
- Fixed latency is 34 cycles with the early-out macro undefined.
- The next divide can be accepted at the earliest in cycle 35, the first IDLE cycle.
- `result` is registered and is stable from cycle 34 until the next accepted start.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - Divisor 0, signed overflow, or |a| < |b| (unsigned compare of magnitudes) skips CALC.
  - For these cases, IDLE goes directly to FIX, `done` asserts in cycle 2, and `busy` is high in cycles 0–1.
  - FIX for |a| < |b| gives quotient 0 and remainder = dividend.
  - All other cases keep the 34-cycle latency.
- Undefined: every operation takes 34 cycles and uses no early-out comparator logic.

## Structure
- Shared package `rv32_pkg`:
  - funct3 constants `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU`
  - state enum `div_state_t`
  - `DIV_ITERS` = 32
  - constants `DIV_BY_ZERO_Q` = 0xFFFFFFFF and `INT_MIN` = 0x80000000
- One combinational sub-module, `div_step`: a 33-bit trial subtract/shift that takes {rem, dividend_msb, divisor} and returns {next_rem, q_bit}. It is instantiated once.

## Test plan
- DIVU 100/7 at cycle 0 → `busy` high in cycles 0–33, `done` in cycle 34, `result`=14. Same operands with REMU → 2.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIV 7/−2 → 0xFFFFFFFD. REM 7/−2 → 1.
- DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIVU 0xFFFFFFFF/0 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- `flush_e` in cycle 10 of a DIVU → `busy`=0 in cycle 11, no `done`, `result` keeps its old value. A following DIVU 9/3 then yields 3 at its own cycle 34.
- With `DIV_EARLY_OUT_EN`: DIVU 3/10 → `done` in cycle 2, `result`=0. REMU 3/10 → 3. DIV 5/0 → `done` in cycle 2, `result`=0xFFFFFFFF. Async reset pulsed in cycle 20 → IDLE and `result`=0 with no `done`.
